// File: rtl/ni_packetizer.sv
// ni_packetizer: local-port NoC transmitter. Turns a descriptor plus a
// stream of payload words into a header flit followed by body flits and
// a tail flit. The output is a single flit register with valid/ready
// handshaking towards the router's local input port.
module ni_packetizer #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_W     = 4,
    parameter logic [2:0] HDR_ID     = 3'b001,
    parameter logic [2:0] BODY_ID    = 3'b010,
    parameter logic [2:0] TAIL_ID    = 3'b100,
    parameter int         MAX_PLD    = 4094
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     cur_addr,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [ADDR_W-1:0]     msg_dst,
    input  logic [11:0]           msg_len,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [28:0]           pld_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  pkt_sent,
    output logic                  err_len
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    localparam logic [11:0] MAX_LEN = 12'(MAX_PLD);

    state_t                state, state_next;
    logic [11:0]           remaining, remaining_next;
    logic [DATA_WIDTH-1:0] flit_q, flit_next;
    logic                  valid_q, valid_next;
    logic                  err_q, err_next;
    logic                  slot_free;
    logic                  len_ok;
    logic                  is_tail_word;

    // The register may take a new flit when empty or when its flit leaves now.
    assign slot_free    = !valid_q || ready_in;
    assign len_ok       = (msg_len != 12'd0) && (msg_len <= MAX_LEN);
    assign is_tail_word = (remaining == 12'd1);

    assign data_out  = flit_q;
    assign valid_out = valid_q;
    assign err_len   = err_q;
    assign pkt_sent  = rst && valid_q && ready_in && (flit_q[DATA_WIDTH-1 -: 3] == TAIL_ID);

    // Handshakes, next state and the next content of the output register.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        flit_next      = flit_q;
        valid_next     = valid_q;
        err_next       = 1'b0;
        msg_ready      = 1'b0;
        pld_ready      = 1'b0;
        if (slot_free) begin
            valid_next = 1'b0;
        end
        case (state)
            IDLE: begin
                msg_ready = rst && slot_free;
                if (msg_valid && msg_ready) begin
                    if (len_ok) begin
                        flit_next      = {HDR_ID, msg_len + 12'd1, msg_dst, cur_addr, 9'd0};
                        valid_next     = 1'b1;
                        remaining_next = msg_len;
                        state_next     = PAYLOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                pld_ready = rst && slot_free;
                if (pld_valid && pld_ready) begin
                    flit_next      = {(is_tail_word ? TAIL_ID : BODY_ID), pld_data};
                    valid_next     = 1'b1;
                    remaining_next = remaining - 12'd1;
                    if (is_tail_word) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, word counter, flit register and error pulse; reset abandons any packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= 12'd0;
            flit_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            flit_q    <= flit_next;
            valid_q   <= valid_next;
            err_q     <= err_next;
        end
    end

endmodule
